// File: rtl/seven_serial_adder_if.sv
// Request/result bundle for the bit-serial operand restorer.
// The master drives the request; the slave (the adder) drives the result.
interface seven_serial_adder_if #(
    parameter int unsigned WIDTH = 7
);
    logic                   start;
    logic [2*WIDTH-1:0]     diff;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       sum;
    logic                   err;

    modport master (
        output start, diff, b,
        input  busy, done, sum, err
    );

    modport slave (
        input  start, diff, b,
        output busy, done, sum, err
    );
endinterface

// File: rtl/seven_serial_adder.sv
// Bit-serial operand restorer: rebuilds a = diff + b one bit per clock through a
// single full-adder cell, flagging bad sign extension or an out-of-range result.
module seven_serial_adder #(
    parameter int unsigned WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seven_serial_adder_if.slave  bus
);
    localparam int unsigned ADD_W = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t             state, state_nxt;
    logic [ADD_W-1:0]   x, x_nxt;
    logic [ADD_W-1:0]   y, y_nxt;
    logic [ADD_W-1:0]   res, res_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               carry, carry_nxt;
    logic               ext_err, ext_err_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic [WIDTH-1:0]   sum_q, sum_nxt;
    logic               err_q, err_nxt;
    logic               s_bit;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            res     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            ext_err <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
            res     <= res_nxt;
            cnt     <= cnt_nxt;
            carry   <= carry_nxt;
            ext_err <= ext_err_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            sum_q   <= sum_nxt;
            err_q   <= err_nxt;
        end
    end

    // Next-state, serial full-adder step and result load
    always_comb begin
        state_nxt   = state;
        x_nxt       = x;
        y_nxt       = y;
        res_nxt     = res;
        cnt_nxt     = cnt;
        carry_nxt   = carry;
        ext_err_nxt = ext_err;
        sum_nxt     = sum_q;
        err_nxt     = err_q;
        done_nxt    = 1'b0;
        s_bit       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    x_nxt       = bus.diff[WIDTH:0];
                    y_nxt       = {1'b0, bus.b};
                    res_nxt     = '0;
                    carry_nxt   = 1'b0;
                    cnt_nxt     = '0;
                    ext_err_nxt = (bus.diff[2*WIDTH-1:WIDTH+1] != {(WIDTH-1){bus.diff[WIDTH]}});
                    state_nxt   = ADD;
                end
            end
            ADD: begin
                s_bit     = x[0] ^ y[0] ^ carry;
                carry_nxt = (x[0] & y[0]) | (x[0] & carry) | (y[0] & carry);
                x_nxt     = x >> 1;
                y_nxt     = y >> 1;
                res_nxt   = {s_bit, res[ADD_W-1:1]};
                cnt_nxt   = cnt + CNT_W'(1);
                // Bit WIDTH of the modular sum is set exactly when the result leaves 0..2^WIDTH-1
                if (cnt == CNT_W'(WIDTH)) begin
                    sum_nxt   = res_nxt[WIDTH-1:0];
                    err_nxt   = res_nxt[WIDTH] | ext_err;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_nxt = (state_nxt == ADD);

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.err  = err_q;
endmodule
